sw_ctrl: RTL and testbench
==========================

SW_CTRL -- requirements
Module: sw_ctrl

Interface
REQ-001 The block SHALL have parameter DEB_CNT, default 65535: the number of consecutive clk cycles a synchronized input must differ from its debounced value before that value updates.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset; asserted when 0.
REQ-004 The block SHALL have port PAUSE_BTN, input, 1 bit: raw, asynchronous pause/resume push button; 1 = pressed.
REQ-005 The block SHALL have port CLR_BTN, input, 1 bit: raw, asynchronous clear push button; 1 = pressed.
REQ-006 The block SHALL have port ADJ, input, 1 bit: raw, asynchronous adjust-mode switch level; 1 = adjust.
REQ-007 The block SHALL have port SEL, input, 1 bit: raw, asynchronous field select; 0 = minutes, 1 = seconds.
REQ-008 The block SHALL have port TICK_1HZ, input, 1 bit: single-cycle, clk-synchronous 1 Hz count pulse.
REQ-009 The block SHALL have port TICK_2HZ, input, 1 bit: single-cycle, clk-synchronous 2 Hz adjust pulse.
REQ-010 The block SHALL have port TICK_BLINK, input, 1 bit: clk-synchronous blink square-wave level.
REQ-011 The block SHALL have port CNT_CLR, output, 1 bit: single-cycle clear pulse to the mm:ss counter.
REQ-012 The block SHALL have port INC_SEC, output, 1 bit: single-cycle pulse that increments the seconds field.
REQ-013 The block SHALL have port CARRY_EN, output, 1 bit: when 1, a seconds wrap 59->00 carries into the minutes field.
REQ-014 The block SHALL have port INC_MIN, output, 1 bit: single-cycle pulse that increments the minutes field, with no carry.
REQ-015 The block SHALL have ports BLANK_MIN and BLANK_SEC, outputs, 1 bit each: when 1, the display blanks that field.
REQ-016 The block SHALL have port STATE, output, 2 bits: current state; RUN=00, PAUSED=01, ADJ_MIN=10, ADJ_SEC=11.

Function
REQ-017 Each of PAUSE_BTN, CLR_BTN, ADJ and SEL SHALL pass through a 2-flop synchronizer, then a debounce counter.
REQ-018 Each debounce counter SHALL count while its synchronized input differs from the debounced value, and clear whenever they match.
REQ-019 A debounced value SHALL take the synchronized value on the cycle its counter reaches DEB_CNT-1, and that counter SHALL clear.
REQ-020 A press event SHALL be a one-cycle pulse on the cycle after the debounced PAUSE_BTN or CLR_BTN goes 0->1; a release SHALL generate nothing.
REQ-021 FSM transitions: RUN + pause press -> PAUSED; PAUSED + pause press -> RUN.
REQ-022 FSM transitions: any state with debounced ADJ=1 -> ADJ_SEC if debounced SEL=1, else ADJ_MIN.
REQ-023 FSM transitions: ADJ_MIN or ADJ_SEC with debounced ADJ=0 -> PAUSED.
REQ-024 The ADJ condition SHALL take priority over a pause press in the same cycle, and a pause press while in adjust SHALL be ignored.
REQ-025 In ADJ_MIN or ADJ_SEC, a change of debounced SEL SHALL move to the other adjust state on the next cycle.
REQ-026 All outputs SHALL be registered, so TICK_x sampled in cycle t produces INC_x in cycle t+1, based on the state in cycle t.
REQ-027 In RUN: INC_SEC = TICK_1HZ delayed one cycle, CARRY_EN=1, INC_MIN=0.
REQ-028 In ADJ_SEC: INC_SEC = TICK_2HZ delayed one cycle, CARRY_EN=0, INC_MIN=0.
REQ-029 In ADJ_MIN: INC_MIN = TICK_2HZ delayed one cycle, INC_SEC=0, CARRY_EN=0.
REQ-030 In PAUSED: INC_SEC=0, INC_MIN=0, CARRY_EN=0.
REQ-031 A clear press SHALL produce CNT_CLR=1 for exactly one cycle in every state, without changing the state.
REQ-032 In the cycle where CNT_CLR=1, INC_SEC and INC_MIN SHALL be forced to 0 (clear wins over increment).
REQ-033 Blanking in RUN: BLANK_MIN=0 and BLANK_SEC=0.
REQ-034 Blanking in PAUSED: BLANK_MIN and BLANK_SEC both equal TICK_BLINK registered.
REQ-035 Blanking in ADJ_MIN: BLANK_MIN = TICK_BLINK registered, BLANK_SEC=0.
REQ-036 Blanking in ADJ_SEC: BLANK_SEC = TICK_BLINK registered, BLANK_MIN=0.
REQ-037 A tick that arrives in the same cycle as a state change SHALL be handled under the old state; it SHALL NOT be lost or duplicated.

Reset
REQ-038 While RESET=0, the following SHALL hold asynchronously: STATE=PAUSED, all outputs 0, all synchronizers, debounced values and debounce counters 0.
REQ-039 On RESET deassertion, the block SHALL start in PAUSED; a button held through reset SHALL produce a press event only after DEB_CNT stable cycles.
REQ-040 Reset asserted mid-debounce or mid-pulse SHALL abort it, with no pulse emitted after release.

Verification (DEB_CNT=4)
REQ-041 Pause toggle: reset release, then PAUSE_BTN held 10 cycles -> exactly one press, STATE 01->00; TICK_1HZ pulse -> INC_SEC=1 and CARRY_EN=1 one cycle later.
REQ-042 Bounce rejection: PAUSE_BTN toggling every 2 cycles for 20 cycles -> no press event, STATE unchanged.
REQ-043 Adjust minutes: ADJ=1, SEL=0 stable -> STATE=10; TICK_2HZ -> INC_MIN=1 and INC_SEC=0; TICK_BLINK=1 -> BLANK_MIN=1, BLANK_SEC=0.
REQ-044 SEL switch: SEL 0->1 in adjust -> STATE=11; TICK_2HZ -> INC_SEC=1 and CARRY_EN=0; ADJ back to 0 -> STATE=01.
REQ-045 Clear collision: in RUN, a clear press event and TICK_1HZ in the same cycle -> CNT_CLR=1 and INC_SEC=0 in the following cycle, STATE stays 00.
REQ-046 Async reset: RESET=0 mid-RUN between clock edges -> STATE=01 and all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/sw_ctrl_if.sv
// Stopwatch control bus: raw switches and timing ticks in, counter/display controls out.
interface sw_ctrl_if;
  logic       PAUSE_BTN;
  logic       CLR_BTN;
  logic       ADJ;
  logic       SEL;
  logic       TICK_1HZ;
  logic       TICK_2HZ;
  logic       TICK_BLINK;
  logic       CNT_CLR;
  logic       INC_SEC;
  logic       CARRY_EN;
  logic       INC_MIN;
  logic       BLANK_MIN;
  logic       BLANK_SEC;
  logic [1:0] STATE;

  modport master (
    output PAUSE_BTN, CLR_BTN, ADJ, SEL, TICK_1HZ, TICK_2HZ, TICK_BLINK,
    input  CNT_CLR, INC_SEC, CARRY_EN, INC_MIN, BLANK_MIN, BLANK_SEC, STATE
  );

  modport slave (
    input  PAUSE_BTN, CLR_BTN, ADJ, SEL, TICK_1HZ, TICK_2HZ, TICK_BLINK,
    output CNT_CLR, INC_SEC, CARRY_EN, INC_MIN, BLANK_MIN, BLANK_SEC, STATE
  );
endinterface

// File: rtl/sw_ctrl.sv
// Stopwatch controller: synchronizes and debounces the user inputs, runs the
// RUN/PAUSED/ADJ_MIN/ADJ_SEC mode FSM and drives registered counter/blank controls.
module sw_ctrl #(
  parameter int DEB_CNT = 65535
) (
  input logic      clk,
  input logic      RESET,
  sw_ctrl_if.slave bus
);

  localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CNT - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    PAUSED  = 2'b01,
    ADJ_MIN = 2'b10,
    ADJ_SEC = 2'b11
  } state_t;

  // Bit order: 0 pause, 1 clear, 2 adjust, 3 select.
  logic [3:0] raw;
  logic [3:0] sync_p0;
  logic [3:0] sync_p1;
  logic [3:0] deb;
  logic [1:0] btn_d;

  assign raw = {bus.SEL, bus.ADJ, bus.CLR_BTN, bus.PAUSE_BTN};

  // Stage boundary: two-flop synchronizer, plus previous debounced button levels.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      btn_d   <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      btn_d   <= deb[1:0];
    end
  end

  // Stage boundary: per-input debounce, value updates after DEB_CNT differing cycles.
  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             lvl;

    always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync_p1[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt <= '0;
        lvl <= sync_p1[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb[i] = lvl;
  end

  logic pause_evt;
  logic clr_evt;
  logic adj_lvl;
  logic sel_lvl;

  assign pause_evt = deb[0] & ~btn_d[0];
  assign clr_evt   = deb[1] & ~btn_d[1];
  assign adj_lvl   = deb[2];
  assign sel_lvl   = deb[3];

  state_t state;
  logic   cnt_clr;
  logic   inc_sec;
  logic   carry_en;
  logic   inc_min;
  logic   blank_min;
  logic   blank_sec;

  // Stage boundary: mode FSM and registered outputs, all decoded from the current state.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state     <= PAUSED;
      cnt_clr   <= 1'b0;
      inc_sec   <= 1'b0;
      carry_en  <= 1'b0;
      inc_min   <= 1'b0;
      blank_min <= 1'b0;
      blank_sec <= 1'b0;
    end else begin
      if (adj_lvl) begin
        state <= sel_lvl ? ADJ_SEC : ADJ_MIN;
      end else if (state == ADJ_MIN || state == ADJ_SEC) begin
        state <= PAUSED;
      end else if (pause_evt) begin
        state <= (state == RUN) ? PAUSED : RUN;
      end

      cnt_clr   <= clr_evt;
      inc_sec   <= ~clr_evt & (((state == RUN) & bus.TICK_1HZ) |
                               ((state == ADJ_SEC) & bus.TICK_2HZ));
      inc_min   <= ~clr_evt & (state == ADJ_MIN) & bus.TICK_2HZ;
      carry_en  <= (state == RUN);
      blank_min <= bus.TICK_BLINK & ((state == PAUSED) | (state == ADJ_MIN));
      blank_sec <= bus.TICK_BLINK & ((state == PAUSED) | (state == ADJ_SEC));
    end
  end

  assign bus.STATE     = state;
  assign bus.CNT_CLR   = cnt_clr;
  assign bus.INC_SEC   = inc_sec;
  assign bus.CARRY_EN  = carry_en;
  assign bus.INC_MIN   = inc_min;
  assign bus.BLANK_MIN = blank_min;
  assign bus.BLANK_SEC = blank_sec;

endmodule

// File: tb/tb_sw_ctrl.sv
// Bench for sw_ctrl with DEB_CNT=4: scenario tasks queue expected output words,
// a negedge monitor pops and compares them on the cycle they are due.
module tb_sw_ctrl;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic RESET;

  always #5 clk = ~clk;

  sw_ctrl_if bus ();

  sw_ctrl #(.DEB_CNT(DEB)) dut (
    .clk  (clk),
    .RESET(RESET),
    .bus  (bus)
  );

  // Output word: STATE[7:6] CNT_CLR[5] INC_SEC[4] CARRY_EN[3] INC_MIN[2] BLANK_MIN[1] BLANK_SEC[0]
  logic [7:0] obs;
  assign obs = {bus.STATE, bus.CNT_CLR, bus.INC_SEC, bus.CARRY_EN,
                bus.INC_MIN, bus.BLANK_MIN, bus.BLANK_SEC};

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ncnt  = 0;

  always @(posedge clk) ncnt <= ncnt + 1;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= ncnt) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (mon_e.cyc != ncnt || obs !== mon_e.val) begin
        n_bad++;
        $display("FAIL %s: cycle %0d got %b expected %b (due cycle %0d)",
                 mon_e.name, ncnt, obs, mon_e.val, mon_e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Queue an expected output word k negedges from now (k >= 1).
  task automatic sb_push(input int k, input string nm, input logic [7:0] v);
    sb.push_back('{cyc: ncnt + k, name: nm, val: v});
  endtask

  task automatic test_reset;
    bus.PAUSE_BTN = 1'b0; bus.CLR_BTN = 1'b0; bus.ADJ = 1'b0; bus.SEL = 1'b0;
    bus.TICK_1HZ = 1'b0; bus.TICK_2HZ = 1'b0; bus.TICK_BLINK = 1'b0;
    RESET = 1'b0;
    step(3);
    n_cmp++;
    if (obs !== 8'h40) begin
      n_bad++;
      $display("FAIL reset_hold: got %b expected %b", obs, 8'h40);
    end
    RESET = 1'b1;
    for (int k = 1; k <= 4; k++) sb_push(k, "reset_idle", 8'h40);
    step(5);
  endtask

  task automatic test_pause_toggle;
    sb_push(6, "pause_before", 8'h40);
    sb_push(7, "pause_run", 8'h00);
    sb_push(8, "pause_carry", 8'h08);
    for (int k = 9; k <= 18; k++) sb_push(k, "pause_once", 8'h08);
    bus.PAUSE_BTN = 1'b1;
    step(10);
    bus.PAUSE_BTN = 1'b0;
    step(9);
    sb_push(1, "run_inc_sec", 8'h18);
    sb_push(2, "run_inc_done", 8'h08);
    bus.TICK_1HZ = 1'b1;
    step(1);
    bus.TICK_1HZ = 1'b0;
    step(3);
  endtask

  task automatic test_bounce;
    for (int k = 1; k <= 28; k++) sb_push(k, "bounce_run", 8'h08);
    for (int i = 0; i < 20; i++) begin
      bus.PAUSE_BTN = ((i / 2) % 2 == 0);
      step(1);
    end
    bus.PAUSE_BTN = 1'b0;
    step(9);
  endtask

  task automatic test_adjust_min;
    sb_push(6, "adjmin_before", 8'h08);
    sb_push(7, "adjmin_enter", 8'h88);
    sb_push(8, "adjmin_idle", 8'h80);
    bus.SEL = 1'b0;
    bus.ADJ = 1'b1;
    step(9);
    sb_push(1, "adjmin_inc", 8'h84);
    sb_push(2, "adjmin_inc_done", 8'h80);
    bus.TICK_2HZ = 1'b1;
    step(1);
    bus.TICK_2HZ = 1'b0;
    step(2);
    sb_push(1, "adjmin_blank", 8'h82);
    sb_push(2, "adjmin_blank2", 8'h82);
    sb_push(3, "adjmin_unblank", 8'h80);
    bus.TICK_BLINK = 1'b1;
    step(2);
    bus.TICK_BLINK = 1'b0;
    step(3);
  endtask

  task automatic test_sel_switch;
    sb_push(6, "sel_before", 8'h80);
    sb_push(7, "sel_adjsec", 8'hC0);
    bus.SEL = 1'b1;
    step(9);
    sb_push(1, "adjsec_inc", 8'hD0);
    sb_push(2, "adjsec_inc_done", 8'hC0);
    bus.TICK_2HZ = 1'b1;
    step(1);
    bus.TICK_2HZ = 1'b0;
    step(2);
    sb_push(1, "adjsec_blank", 8'hC1);
    sb_push(2, "adjsec_unblank", 8'hC0);
    bus.TICK_BLINK = 1'b1;
    step(1);
    bus.TICK_BLINK = 1'b0;
    step(2);
    sb_push(6, "adjexit_before", 8'hC0);
    sb_push(7, "adjexit_paused", 8'h40);
    bus.ADJ = 1'b0;
    step(9);
    sb_push(1, "paused_blank", 8'h43);
    sb_push(2, "paused_unblank", 8'h40);
    bus.TICK_BLINK = 1'b1;
    bus.TICK_1HZ = 1'b1;
    bus.TICK_2HZ = 1'b1;
    step(1);
    bus.TICK_BLINK = 1'b0;
    bus.TICK_1HZ = 1'b0;
    bus.TICK_2HZ = 1'b0;
    step(3);
  endtask

  task automatic test_clear_collision;
    sb_push(7, "clr_goto_run", 8'h00);
    sb_push(8, "clr_run", 8'h08);
    bus.PAUSE_BTN = 1'b1;
    step(10);
    bus.PAUSE_BTN = 1'b0;
    step(9);
    sb_push(6, "clr_before", 8'h08);
    sb_push(7, "clr_wins", 8'h28);
    for (int k = 8; k <= 20; k++) sb_push(k, "clr_single", 8'h08);
    bus.CLR_BTN = 1'b1;
    step(6);
    bus.TICK_1HZ = 1'b1;
    step(1);
    bus.TICK_1HZ = 1'b0;
    step(5);
    bus.CLR_BTN = 1'b0;
    step(10);
  endtask

  task automatic test_tick_on_transition;
    sb_push(6, "trans_before", 8'h08);
    sb_push(7, "trans_old_state", 8'h58);
    sb_push(8, "trans_paused", 8'h40);
    bus.PAUSE_BTN = 1'b1;
    step(6);
    bus.TICK_1HZ = 1'b1;
    step(1);
    bus.TICK_1HZ = 1'b0;
    step(4);
    bus.PAUSE_BTN = 1'b0;
    step(9);
    sb_push(6, "clr_paused_before", 8'h40);
    sb_push(7, "clr_paused", 8'h60);
    sb_push(8, "clr_paused_after", 8'h40);
    bus.CLR_BTN = 1'b1;
    step(10);
    bus.CLR_BTN = 1'b0;
    step(9);
  endtask

  task automatic test_async_reset;
    sb_push(7, "areset_goto_run", 8'h00);
    sb_push(8, "areset_run", 8'h08);
    bus.PAUSE_BTN = 1'b1;
    step(10);
    bus.PAUSE_BTN = 1'b0;
    step(9);
    bus.TICK_BLINK = 1'b1;
    #2;
    RESET = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 8'h40) begin
      n_bad++;
      $display("FAIL async_reset: got %b expected %b", obs, 8'h40);
    end
    bus.TICK_BLINK = 1'b0;
    step(2);
  endtask

  task automatic test_held_through_reset;
    bus.PAUSE_BTN = 1'b1;
    step(2);
    RESET = 1'b1;
    sb_push(6, "held_before", 8'h40);
    sb_push(7, "held_press", 8'h00);
    sb_push(8, "held_run", 8'h08);
    step(10);
    bus.PAUSE_BTN = 1'b0;
    step(9);
  endtask

  task automatic test_reset_abort;
    bus.PAUSE_BTN = 1'b1;
    step(3);
    RESET = 1'b0;
    bus.PAUSE_BTN = 1'b0;
    step(1);
    RESET = 1'b1;
    for (int k = 1; k <= 12; k++) sb_push(k, "abort_debounce", 8'h40);
    step(13);
    bus.PAUSE_BTN = 1'b1;
    step(6);
    RESET = 1'b0;
    bus.PAUSE_BTN = 1'b0;
    step(1);
    RESET = 1'b1;
    for (int k = 1; k <= 12; k++) sb_push(k, "abort_pulse", 8'h40);
    step(13);
  endtask

  initial begin
    test_reset();
    test_pause_toggle();
    test_bounce();
    test_adjust_min();
    test_sel_switch();
    test_clear_collision();
    test_tick_on_transition();
    test_async_reset();
    test_held_through_reset();
    test_reset_abort();
    step(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
